// File: rtl/fact_ctrl.sv
// Controller for the iterative factorial datapath: sequences counter load/decrement,
// product mux, F register write and output buffer from a level go/done handshake.
module fact_ctrl #(
    parameter int IWIDE = 4,
    parameter int OWIDE = 32,
    parameter int MAX_N = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [IWIDE-1:0] n,
    input  logic             greater,
    output logic             cld,
    output logic             cen,
    output logic             s1,
    output logic             ren,
    output logic             ben,
    output logic             busy,
    output logic             done,
    output logic             err
);

    // Largest k with k! representable in OWIDE bits; guards against a MAX_N
    // that is set larger than the result width can actually hold.
    function automatic int max_fit(input int w);
        logic [127:0] f;
        f = 128'd1;
        for (int k = 1; k <= 33; k++) begin
            f = f * 128'(k);
            if ((f >> w) != 128'd0) return k - 1;
        end
        return 33;
    endfunction

    localparam int          FIT     = max_fit(OWIDE);
    localparam int          LIMIT   = (MAX_N < FIT) ? MAX_N : FIT;
    localparam logic [31:0] LIMIT_U = 32'(LIMIT);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_MULT  = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_e;

    state_e state_q, state_d;
    logic   n_too_big;

    assign n_too_big = 32'(n) > LIMIT_U;

    always_ff @(posedge clk) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (go) state_d = n_too_big ? S_ERR : S_LOAD;
            end
            S_LOAD:  state_d = S_CHECK;
            S_CHECK: state_d = greater ? S_MULT : S_DONE;
            S_MULT:  state_d = S_CHECK;
            S_DONE:  if (!go) state_d = S_IDLE;
            S_ERR:   if (!go) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes decode from the registered state only, so go never reaches them combinationally.
    always_comb begin
        cld  = 1'b0;
        cen  = 1'b0;
        s1   = 1'b0;
        ren  = 1'b0;
        ben  = 1'b0;
        busy = 1'b0;
        done = 1'b0;
        err  = 1'b0;
        case (state_q)
            S_LOAD: begin
                cld  = 1'b1;
                ren  = 1'b1;
                busy = 1'b1;
            end
            S_CHECK: busy = 1'b1;
            S_MULT: begin
                s1   = 1'b1;
                ren  = 1'b1;
                cen  = 1'b1;
                busy = 1'b1;
            end
            S_DONE: begin
                ben  = 1'b1;
                done = 1'b1;
            end
            S_ERR:   err = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fact_ctrl.sv
// Directed bench for fact_ctrl with a behavioural datapath and a result scoreboard.
module tb_fact_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       go;
    logic [3:0] n;
    logic       greater;
    logic       cld, cen, s1, ren, ben, busy, done, err;

    always #5 clk = ~clk;

    fact_ctrl #(.IWIDE(4), .OWIDE(32), .MAX_N(12)) dut (
        .clk(clk), .rst(rst), .go(go), .n(n), .greater(greater),
        .cld(cld), .cen(cen), .s1(s1), .ren(ren), .ben(ben),
        .busy(busy), .done(done), .err(err)
    );

    // Datapath: counter N, compare N>1, F register fed by 1/F*N mux, output buffer.
    logic [3:0]  dp_n = 4'd0;
    logic [31:0] dp_f = 32'd0;
    wire  [31:0] out  = ben ? dp_f : 32'd0;
    wire  [7:0]  outs = {cld, cen, s1, ren, ben, busy, done, err};
    assign greater = dp_n > 4'd1;

    always @(posedge clk) begin
        if (cld)      dp_n <= n;
        else if (cen) dp_n <= dp_n - 4'd1;
        if (ren)      dp_f <= s1 ? dp_f * {28'd0, dp_n} : 32'd1;
    end

    typedef struct {
        bit          is_err;
        logic [31:0] res;
        int          lat;
    } exp_t;
    exp_t sb[$];

    int checks   = 0;
    int failures = 0;
    bit seen_cld, seen_cen, seen_ren;

    function automatic logic [31:0] fact(input int k);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 2; i <= k; i++) r = r * 32'(i);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        seen_cld |= cld;
        seen_cen |= cen;
        seen_ren |= ren;
        chk("cld_cen_excl", 64'(cld & cen), 64'd0);
        chk("done_err_busy_onehot0", 64'($onehot0({done, err, busy})), 64'd1);
        chk("ren_only_load_mult", 64'(ren & ~(cld | cen)), 64'd0);
    endtask

    // drop_after > 0 lowers go after that many cycles of the computation.
    task automatic run_req(input int nv, input int drop_after);
        exp_t e, got;
        int   c;
        bit   first_cld;
        e.is_err = nv > 12;
        e.res    = fact(nv);
        e.lat    = e.is_err ? 1 : 3 + 2 * ((nv > 1) ? nv - 1 : 0);
        sb.push_back(e);
        seen_cld = 0; seen_cen = 0; seen_ren = 0;
        first_cld = 0;
        go = 1'b1;
        n  = 4'(nv);
        c  = 0;
        while (!(done || err) && c < 80) begin
            step();
            c++;
            if (c == 1) first_cld = cld;
            if (c == drop_after) go = 1'b0;
        end
        got = sb.pop_front();
        chk("timeout", 64'(done | err), 64'd1);
        chk("latency", 64'(c), 64'(got.lat));
        chk("err_kind", 64'(err), 64'(got.is_err));
        if (!got.is_err) begin
            chk("result", 64'(out), 64'(got.res));
            chk("ben_in_done", 64'(ben), 64'd1);
            chk("cld_first_cycle", 64'(first_cld), 64'd1);
        end else begin
            chk("err_no_cld", 64'(seen_cld), 64'd0);
            chk("err_no_ren", 64'(seen_ren), 64'd0);
            chk("err_busy", 64'(busy), 64'd0);
            chk("err_ben", 64'(ben), 64'd0);
        end
        if (nv <= 1) chk("no_mult_cycle", 64'(seen_cen), 64'd0);
    endtask

    task automatic finish_req(input int hold);
        logic [31:0] o;
        bit          e;
        o = out;
        e = err;
        for (int i = 0; i < hold; i++) begin
            step();
            chk("hold_state", 64'({done, err}), e ? 64'd1 : 64'd2);
            chk("hold_out", 64'(out), e ? 64'd0 : 64'(o));
        end
        go = 1'b0;
        step();
        chk("idle_outs", 64'(outs), 64'd0);
    endtask

    initial begin
        rst = 1'b0;
        go  = 1'b1;
        n   = 4'd3;
        step();
        chk("reset_outs_1", 64'(outs), 64'd0);
        step();
        chk("reset_outs_2", 64'(outs), 64'd0);
        rst = 1'b1;
        run_req(3, -1);
        finish_req(2);

        run_req(5, -1);
        finish_req(3);
        run_req(0, -1);
        finish_req(1);
        run_req(1, -1);
        finish_req(1);
        run_req(12, -1);
        finish_req(1);
        run_req(13, -1);
        finish_req(2);
        run_req(15, -1);
        finish_req(0);

        // Reset in the middle of a 7! computation.
        go = 1'b1;
        n  = 4'd7;
        repeat (5) step();
        chk("pre_reset_busy", 64'(busy), 64'd1);
        rst = 1'b0;
        step();
        chk("midrst_outs", 64'(outs), 64'd0);
        step();
        chk("midrst_outs_held", 64'(outs), 64'd0);
        rst = 1'b1;
        go  = 1'b0;
        step();
        chk("post_reset_idle", 64'(outs), 64'd0);
        run_req(4, -1);
        finish_req(1);

        // go dropped mid-computation: done lasts one cycle.
        run_req(3, 2);
        step();
        chk("drop_done_one_cycle", 64'(outs), 64'd0);

        // Back-to-back with a single go-low edge between requests.
        run_req(3, -1);
        finish_req(1);
        run_req(4, -1);
        finish_req(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fact_ctrl.md
Name: fact_ctrl

Overview:
- Control unit for the iterative factorial datapath: counter N, compare N>1, multiplier F*N, 1/product mux, F register, output buffer.
- Sequences datapath strobes (cld, cen, s1, ren, ben) from a level go/done handshake.
- Rejects inputs whose factorial overflows the OWIDE-bit result.
- Sits beside the datapath in the processor tile; the top level wires its strobes straight to the datapath control pins.

Parameters:
- IWIDE, 4, width of n and of the datapath counter.
- OWIDE, 32, width of the datapath result (informational; sets MAX_N).
- MAX_N, 12, largest n accepted; 12! fits 32 bits. n > MAX_N raises err.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-low reset; sampled on clk rising edge.
- go  input  1  request, level; held high by the requester until done or err, then dropped.
- n  input  IWIDE  operand; sampled only on the edge that leaves IDLE.
- greater  input  1  datapath compare result, N > 1 (combinational from counter).
- cld  output  1  counter load (N <= n).
- cen  output  1  counter decrement enable (N <= N-1).
- s1  output  1  mux select: 0 = constant 1, 1 = product F*N.
- ren  output  1  F register write enable.
- ben  output  1  output buffer enable (drives result bus).
- busy  output  1  high in LOAD, CHECK and MULT.
- done  output  1  result valid.
- err  output  1  operand rejected.

Behaviour:
- All outputs are registered or decoded purely from the registered state; no output depends combinationally on go.
- Reset: rst=0 at any edge forces state to IDLE. All outputs are 0 from that edge on, including mid-computation. go sampled on a reset edge is ignored.
- States: IDLE, LOAD, CHECK, MULT, DONE, ERR. Encoding is free; unused encodings go to IDLE on the next edge.
- IDLE: all strobes 0.
  - go=1 and n <= MAX_N -> LOAD.
  - go=1 and n > MAX_N -> ERR.
  - Otherwise stay in IDLE.
- LOAD: cld=1, s1=0, ren=1, cen=0, so N <= n and F <= 1 in the same edge. Always -> CHECK.
- CHECK: no strobes.
  - greater=1 -> MULT.
  - greater=0 -> DONE (covers n=0 and n=1, result 1).
- MULT: s1=1, ren=1, cen=1, so F <= F*N and N <= N-1 on the same edge. Always -> CHECK.
- DONE: ben=1, done=1. Stay while go=1; go=0 -> IDLE. F is untouched (ren=0), so the result stays stable on the bus.
- ERR: err=1, ben=0. Stay while go=1; go=0 -> IDLE.
- busy=1 exactly in LOAD, CHECK and MULT. done, err and busy are mutually exclusive.
- cld and cen are never both 1. ren=1 only in LOAD and MULT.
- Latency: with go sampled at edge 0, done rises after edge 3 + 2*max(n-1,0). Examples: n=1 -> 3 cycles, n=5 -> 11, n=12 -> 25.
- go dropped mid-computation: computation completes, DONE is entered, and the block returns to IDLE on the next edge (done is high for one cycle).
- go held high through DONE and low for one edge, then high again: a new request is accepted from IDLE on the following edge, with n re-sampled.
- n is not held internally; the datapath counter is the only copy after LOAD.

Test Plan:
- Reset: rst=0 for 2 edges while go=1 -> all outputs 0, state IDLE. After rst=1 with go=1 and n=3 -> cld=1 on the next cycle.
- n=5, go held: strobe sequence LOAD, then (CHECK, MULT) x4, CHECK, DONE. done=1 at cycle 11, datapath out=120, ben=1 until go=0.
- n=0 and n=1: done at cycle 3, out=1, no MULT cycle (cen never asserted).
- n=12 -> out=479001600 at cycle 25. n=13 -> err=1 one edge after go, no cld/ren ever asserted, busy=0.
- Reset mid-operation: n=7, rst=0 at cycle 6 -> all outputs 0 from that edge. A fresh request with n=4 then yields out=24 at cycle 9.
- Back-to-back: n=3 done, go=0 for one cycle, go=1 with n=4 -> second done with out=24. Check cld and cen never both 1, and done/err/busy one-hot-or-zero throughout.
